// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the conv instruction path: default geometry of an
//   instruction (word width, words per instruction, RAM address width), the
//   bit positions of the fields inside an assembled instruction, and the state
//   encoding of the instruction-fetch FSM.
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int IRW_DEF = 31;   // instruction RAM word width
    localparam int IN_DEF  = 3;    // RAM words per instruction
    localparam int IAW_DEF = 10;   // instruction RAM address width

    // Field positions within the assembled IRW*IN instruction bus
    localparam int FC_BIT   = 0;
    localparam int BASE_LSB = 8;
    localparam int BASE_MSB = 21;
    localparam int DIM0_LSB = 22;
    localparam int DIM0_MSB = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/axi_frs.sv
// ----------------------------------------------------------------------------
// axi_frs
//   Forward register slice on a valid/ready interface. Outputs are fully
//   registered; a new beat is accepted in the same cycle the held one is
//   consumed, so a continuously ready sink sees no bubbles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data payload (DW bits)
//   out_valid/out_ready   downstream handshake, out_data payload (DW bits)
// ----------------------------------------------------------------------------
module axi_frs #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // Empty, or the held beat leaves this cycle
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/conv_inst_fetch.sv
// ----------------------------------------------------------------------------
// conv_inst_fetch
//   Reads a run of conv instructions (IN words of IRW bits each) from the
//   instruction RAM (1-cycle read latency), assembles each into one IRW*IN
//   bus and hands them downstream over valid/ready through an axi_frs slice.
//   done pulses once the last instruction has been accepted.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    one-cycle start pulse, sampled only in IDLE
//   inst_base_addr, inst_num first word address and instruction count
//   busy, done               run in progress / one-cycle completion pulse
//   ram_ren, ram_addr        RAM read request
//   ram_rdata                RAM data, valid the cycle after ram_ren
//   out_inst, out_valid,
//   out_ready                assembled instruction stream
//   perf_stall_cnt           (CONV_INST_FETCH_PERF_EN only) saturating count
//                            of busy cycles stalled by downstream backpressure
// Optional feature macro: CONV_INST_FETCH_PERF_EN
// ----------------------------------------------------------------------------
module conv_inst_fetch
    import conv_pkg::*;
#(
    parameter int IRW = IRW_DEF,
    parameter int IN  = IN_DEF,
    parameter int IAW = IAW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IAW-1:0]    inst_base_addr,
    input  logic [IAW-1:0]    inst_num,
    output logic              busy,
    output logic              done,
    output logic              ram_ren,
    output logic [IAW-1:0]    ram_addr,
    input  logic [IRW-1:0]    ram_rdata,
    output logic [IRW*IN-1:0] out_inst,
    output logic              out_valid,
    input  logic              out_ready
`ifdef CONV_INST_FETCH_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt
`endif
);

    localparam int WCW = (IN > 1) ? $clog2(IN) : 1;
    localparam int DW  = IRW * IN;

    fetch_state_e state_q, state_d;

    logic [IAW-1:0] addr_q, addr_d;
    logic [IAW-1:0] num_q, num_d;
    logic [IAW-1:0] inst_cnt_q, inst_cnt_d;   // instructions fully issued
    logic [IAW-1:0] out_cnt_q, out_cnt_d;     // instructions accepted downstream
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [WCW-1:0] cap_idx_q, cap_idx_d;
    logic           cap_vld_q, cap_vld_d;
    logic           issue_done_q, issue_done_d;
    logic           buf_full_q, buf_full_d;
    logic [IN-1:0][IRW-1:0] buf_q, buf_d;
    logic [IN-1:0][IRW-1:0] asm_inst;

    logic start_acc;
    logic last_word;
    logic last_inst;
    logic landing_last;
    logic buf_avail;
    logic xfer;
    logic frs_in_ready;
    logic out_hs;

    assign start_acc    = (state_q == ST_IDLE) && start;
    assign last_word    = (word_cnt_q == WCW'(IN - 1));
    assign last_inst    = (inst_cnt_q == num_q - IAW'(1));
    assign landing_last = cap_vld_q && (cap_idx_q == WCW'(IN - 1));
    assign out_hs       = out_valid && out_ready;

    // The final word is forwarded straight from ram_rdata in the cycle it
    // lands, so the buffer counts as full one cycle early and the next
    // instruction's reads can start IN+1 cycles after the previous ones.
    assign buf_avail = buf_full_q || landing_last;
    assign xfer      = buf_avail && frs_in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = (inst_num == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                if (ram_ren && last_word && last_inst) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_hs && (out_cnt_q == num_q - IAW'(1))) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        ram_ren = (state_q == ST_FETCH) && !issue_done_q && !buf_full_q;
    end

    // ---------------- Address, counters and assembly buffer ----------------
    always_comb begin
        addr_d       = addr_q;
        num_d        = num_q;
        inst_cnt_d   = inst_cnt_q;
        out_cnt_d    = out_cnt_q;
        word_cnt_d   = word_cnt_q;
        issue_done_d = issue_done_q;
        buf_full_d   = buf_full_q;
        buf_d        = buf_q;
        cap_vld_d    = ram_ren;
        cap_idx_d    = word_cnt_q;
        asm_inst     = buf_q;

        for (int unsigned k = 0; k < IN; k++) begin
            if (cap_vld_q && (cap_idx_q == WCW'(k))) begin
                buf_d[k]    = ram_rdata;
                asm_inst[k] = ram_rdata;
            end
        end

        if (ram_ren) begin
            addr_d = addr_q + IAW'(1);
            if (last_word) begin
                word_cnt_d   = '0;
                inst_cnt_d   = inst_cnt_q + IAW'(1);
                issue_done_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + WCW'(1);
            end
        end

        if (xfer) begin
            buf_full_d   = 1'b0;
            issue_done_d = 1'b0;
        end else if (landing_last) begin
            buf_full_d = 1'b1;
        end

        if (out_hs) out_cnt_d = out_cnt_q + IAW'(1);

        if (start_acc) begin
            addr_d       = inst_base_addr;
            num_d        = inst_num;
            inst_cnt_d   = '0;
            out_cnt_d    = '0;
            word_cnt_d   = '0;
            issue_done_d = 1'b0;
            buf_full_d   = 1'b0;
            cap_vld_d    = 1'b0;
            buf_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            num_q        <= '0;
            inst_cnt_q   <= '0;
            out_cnt_q    <= '0;
            word_cnt_q   <= '0;
            cap_idx_q    <= '0;
            cap_vld_q    <= 1'b0;
            issue_done_q <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_q        <= '0;
        end else begin
            addr_q       <= addr_d;
            num_q        <= num_d;
            inst_cnt_q   <= inst_cnt_d;
            out_cnt_q    <= out_cnt_d;
            word_cnt_q   <= word_cnt_d;
            cap_idx_q    <= cap_idx_d;
            cap_vld_q    <= cap_vld_d;
            issue_done_q <= issue_done_d;
            buf_full_q   <= buf_full_d;
            buf_q        <= buf_d;
        end
    end

    assign ram_addr = addr_q;

    // ---------------- Output register slice ----------------
    axi_frs #(
        .DW (DW)
    ) u_frs (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (buf_avail),
        .in_ready  (frs_in_ready),
        .in_data   (asm_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_inst)
    );

`ifdef CONV_INST_FETCH_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (start_acc) begin
            perf_d = '0;
        end else if (busy && out_valid && !out_ready && (perf_q != '1)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_conv_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_conv_inst_fetch
//   Directed bench for conv_inst_fetch with a RAM model whose word at address
//   a holds a. A monitor logs reads, handshakes and done pulses per cycle.
// ----------------------------------------------------------------------------
module tb_conv_inst_fetch;

    localparam int IRW = 31;
    localparam int IN  = 3;
    localparam int IAW = 10;
    localparam int DW  = IRW * IN;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [IAW-1:0] inst_base_addr = '0;
    logic [IAW-1:0] inst_num = '0;
    logic           busy, done, ram_ren, out_valid;
    logic [IAW-1:0] ram_addr;
    logic [IRW-1:0] ram_rdata = '0;
    logic [DW-1:0]  out_inst;
    logic           out_ready = 1'b0;
`ifdef CONV_INST_FETCH_PERF_EN
    logic [15:0]    perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    conv_inst_fetch #(
        .IRW (IRW),
        .IN  (IN),
        .IAW (IAW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .inst_base_addr (inst_base_addr),
        .inst_num       (inst_num),
        .busy           (busy),
        .done           (done),
        .ram_ren        (ram_ren),
        .ram_addr       (ram_addr),
        .ram_rdata      (ram_rdata),
        .out_inst       (out_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
`ifdef CONV_INST_FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: word at address a holds a, one-cycle read latency
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= IRW'(ram_addr);
    end

    // Monitor logs
    int             cyc = 0;
    int             start_cyc = -1;
    logic [IAW-1:0] rd_q[$];
    logic [DW-1:0]  hs_q[$];
    int             hs_cyc_q[$];
    int             done_cyc_q[$];
    int             valid_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (ram_ren) rd_q.push_back(ram_addr);
            if (out_valid && out_ready) begin
                hs_q.push_back(out_inst);
                hs_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
            if (start) start_cyc = cyc;
            if (out_valid) valid_cnt++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        hs_q.delete();
        hs_cyc_q.delete();
        done_cyc_q.delete();
        valid_cnt = 0;
        start_cyc = -1;
    endtask

    task automatic pulse_start(input logic [IAW-1:0] base, input logic [IAW-1:0] num);
        inst_base_addr = base;
        inst_num       = num;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done_cyc_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (done_cyc_q.size() > 0) ok = 1'b1;
    endtask

    function automatic logic [DW-1:0] exp_inst(input int unsigned a);
        logic [IAW-1:0] a0, a1, a2;
        a0 = IAW'(a);
        a1 = IAW'(a + 1);
        a2 = IAW'(a + 2);
        return {IRW'(a2), IRW'(a1), IRW'(a0)};
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++;
        if (ram_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got=%0b exp=0", ram_ren); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++;
        if (ram_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
        checks++;
        if (out_inst !== '0) begin errors++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        clear_logs();
        out_ready = 1'b1;
        pulse_start(10'h010, 10'd2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        wait_done(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done_timeout got=0 exp=1"); end
        checks++;
        if (hs_q.size() != 2) begin errors++; $display("FAIL basic_count got=%0d exp=2", hs_q.size()); end
        if (hs_q.size() == 2) begin
            checks++;
            if (hs_q[0] !== {31'h012, 31'h011, 31'h010}) begin
                errors++; $display("FAIL basic_inst0 got=%h exp=%h", hs_q[0], {31'h012, 31'h011, 31'h010});
            end
            checks++;
            if (hs_q[1] !== {31'h015, 31'h014, 31'h013}) begin
                errors++; $display("FAIL basic_inst1 got=%h exp=%h", hs_q[1], {31'h015, 31'h014, 31'h013});
            end
            checks++;
            if (done_cyc_q.size() != 1 || done_cyc_q[0] != hs_cyc_q[1] + 1) begin
                errors++; $display("FAIL basic_done_timing got_pulses=%0d exp_cycle_after_hs=%0d", done_cyc_q.size(), hs_cyc_q[1] + 1);
            end
        end
        checks++;
        if (rd_q.size() != 6) begin errors++; $display("FAIL basic_reads got=%0d exp=6", rd_q.size()); end
        for (int i = 0; i < rd_q.size() && i < 6; i++) begin
            checks++;
            if (rd_q[i] !== IAW'(10'h010 + i)) begin
                errors++; $display("FAIL basic_rd_addr[%0d] got=%h exp=%h", i, rd_q[i], IAW'(10'h010 + i));
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after got busy=%0b done=%0b exp 0 0", busy, done);
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_logs();
        out_ready = 1'b1;
        pulse_start(10'h050, 10'd0);
        wait_done(10, ok);
        checks++;
        if (!ok || done_cyc_q[0] - start_cyc > 2) begin
            errors++; $display("FAIL zero_done got_ok=%0b exp done within 2 cycles", ok);
        end
        tick();
        tick();
        checks++;
        if (rd_q.size() != 0) begin errors++; $display("FAIL zero_reads got=%0d exp=0", rd_q.size()); end
        checks++;
        if (valid_cnt != 0) begin errors++; $display("FAIL zero_valid got=%0d exp=0", valid_cnt); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        bit stable;
        logic [DW-1:0] held;
        int unsigned max_rd;
        clear_logs();
        out_ready = 1'b0;
        pulse_start(10'h100, 10'd4);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_valid_timeout got=0 exp=1"); end
        held   = out_inst;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_inst !== held || out_valid !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_stable got=unstable exp=stable inst %h", held); end
        checks++;
        if (held !== exp_inst(32'h100)) begin errors++; $display("FAIL bp_held got=%h exp=%h", held, exp_inst(32'h100)); end
        max_rd = 0;
        foreach (rd_q[i]) if (rd_q[i] > max_rd) max_rd = rd_q[i];
        checks++;
        if (rd_q.size() != 6 || max_rd > 32'h105) begin
            errors++; $display("FAIL bp_reads got=%0d max=%h exp=6 max<=105", rd_q.size(), max_rd);
        end
`ifdef CONV_INST_FETCH_PERF_EN
        checks++;
        if (perf_stall_cnt !== 16'd20) begin errors++; $display("FAIL bp_perf got=%0d exp=20", perf_stall_cnt); end
`endif
        out_ready = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done_timeout got=0 exp=1"); end
        checks++;
        if (hs_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", hs_q.size()); end
        for (int i = 0; i < hs_q.size() && i < 4; i++) begin
            checks++;
            if (hs_q[i] !== exp_inst(32'h100 + 3 * i)) begin
                errors++; $display("FAIL bp_inst[%0d] got=%h exp=%h", i, hs_q[i], exp_inst(32'h100 + 3 * i));
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        bit ok;
        logic [IAW-1:0] exp_rd [6];
        exp_rd = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003};
        clear_logs();
        out_ready = 1'b1;
        pulse_start(10'h3FE, 10'd2);
        wait_done(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_done_timeout got=0 exp=1"); end
        checks++;
        if (rd_q.size() != 6) begin errors++; $display("FAIL wrap_reads got=%0d exp=6", rd_q.size()); end
        for (int i = 0; i < rd_q.size() && i < 6; i++) begin
            checks++;
            if (rd_q[i] !== exp_rd[i]) begin
                errors++; $display("FAIL wrap_rd_addr[%0d] got=%h exp=%h", i, rd_q[i], exp_rd[i]);
            end
        end
        if (hs_q.size() == 2) begin
            checks++;
            if (hs_q[0] !== {31'h000, 31'h3FF, 31'h3FE}) begin
                errors++; $display("FAIL wrap_inst0 got=%h exp=%h", hs_q[0], {31'h000, 31'h3FF, 31'h3FE});
            end
            checks++;
            if (hs_q[1] !== {31'h003, 31'h002, 31'h001}) begin
                errors++; $display("FAIL wrap_inst1 got=%h exp=%h", hs_q[1], {31'h003, 31'h002, 31'h001});
            end
        end else begin
            checks++;
            errors++; $display("FAIL wrap_count got=%0d exp=2", hs_q.size());
        end
        tick();
    endtask

    task automatic test_midrun_reset();
        bit ok;
        bit seen;
        clear_logs();
        out_ready = 1'b1;
        pulse_start(10'h020, 10'd3);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hs_q.size() >= 1) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_hs_timeout got=0 exp=1"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, ram_ren, out_valid} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_ctrl got=%b exp=0000", {busy, done, ram_ren, out_valid});
        end
        checks++;
        if (ram_addr !== '0 || out_inst !== '0) begin
            errors++; $display("FAIL mid_reset_data got addr=%h inst=%h exp=0", ram_addr, out_inst);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (done_cyc_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_no_done got pulses=%0d busy=%0b exp 0 0", done_cyc_q.size(), busy);
        end
        clear_logs();
        pulse_start(10'h030, 10'd1);
        tick();
        pulse_start(10'h040, 10'd5);   // issued while busy: must be ignored
        wait_done(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_restart_timeout got=0 exp=1"); end
        checks++;
        if (hs_q.size() != 1) begin errors++; $display("FAIL mid_restart_count got=%0d exp=1", hs_q.size()); end
        if (hs_q.size() >= 1) begin
            checks++;
            if (hs_q[0] !== {31'h032, 31'h031, 31'h030}) begin
                errors++; $display("FAIL mid_restart_inst got=%h exp=%h", hs_q[0], {31'h032, 31'h031, 31'h030});
            end
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (rd_q.size() != 3 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_ignored_start got reads=%0d busy=%0b exp 3 0", rd_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_wrap();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_inst_fetch.md
Name: conv_inst_fetch

Overview:
Upstream feeder of the conv instruction-loop stage. On a start pulse it reads a run of conv instructions from the instruction RAM. Each instruction is IN words of IRW bits, and the RAM has 1-cycle read latency. The block assembles each instruction into one IRW*IN bus and presents it on a valid/ready interface that connects directly to the loop stage's instruction input. It raises done once the last instruction has been accepted downstream.

Parameters:
IRW, 31, instruction word width (one RAM word)
IN, 3, words per instruction; word k maps to out_inst[IRW*(k+1)-1 : IRW*k]
IAW, 10, instruction RAM address width; also width of inst_num

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle start pulse; sampled only in IDLE
inst_base_addr  input  IAW  RAM address of word 0 of the first instruction
inst_num  input  IAW  number of instructions to fetch
busy  output  1  high from the cycle after an accepted start until the done cycle
done  output  1  one-cycle pulse when the run completes
ram_ren  output  1  RAM read enable
ram_addr  output  IAW  RAM read address
ram_rdata  input  IRW  RAM data, valid the cycle after ram_ren
out_inst  output  IRW*IN  assembled instruction; bit 0 = fc, [21:8] = base, [28:22] = dim0 size
out_valid  output  1  instruction valid
out_ready  input  1  downstream ready

Behaviour:
- Reset: FSM = IDLE; busy, done, ram_ren, out_valid = 0; ram_addr, out_inst = 0; all counters and the assembly buffer cleared.
- Reset mid-run: the run is abandoned. No done pulse. The output register is emptied.
- Start with start, inst_base_addr and inst_num latched in IDLE:
  - inst_num = 0: go to DONE with no RAM reads and no output.
  - inst_num > 0: go to FETCH.
- Start pulses outside IDLE are ignored.
- FSM states:
  - IDLE.
  - FETCH: issue reads.
  - DRAIN: all reads issued; waiting for the last instruction to be accepted downstream.
  - DONE: done = 1 for one cycle, then IDLE.
- Read address: a running address register starts at inst_base_addr and increments by 1 per issued read. It wraps modulo 2^IAW with no error.
- Counters: word counter 0..IN-1 and instruction counter 0..inst_num-1.
- Issue rule: ram_ren = 1 in FETCH only while the assembly buffer is not full and reads for the current instruction remain.
- Capture: a delayed copy of ram_ren and the word index writes ram_rdata into the buffer slot one cycle after issue. The slot is fully written when word IN-1 lands.
- Buffer transfer: a full buffer moves into the output register stage when that stage can accept. The buffer is free again in the same cycle.
- Next instruction: reads for the next instruction resume the cycle after the transfer. Minimum spacing is IN+1 cycles per instruction.
- FETCH exit: after the read of word IN-1 of instruction inst_num-1 is issued, go to DRAIN.
- DRAIN exit: go to DONE in the cycle after the last instruction handshake (out_valid && out_ready).
- Output stage: a forward register slice.
  - out_valid stays high and out_inst stays stable until out_ready.
  - A new instruction is loaded in the same cycle as a handshake, so there are no bubbles.
  - out_ready low for any duration only stalls the block; there is no data loss and no extra reads beyond the one pending instruction.
- Order: instructions leave in RAM order. Words are placed by index, never shifted.

Optional Feature:
- Macro: CONV_INST_FETCH_PERF_EN.
- Defined:
  - Extra output perf_stall_cnt, 16 bits.
  - Counts cycles with out_valid && !out_ready while busy.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on each accepted start.
- Undefined: the port and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package conv_pkg holds:
  - IRW and IN defaults.
  - Field constants FC_BIT = 0, BASE_LSB = 8, BASE_MSB = 21, DIM0_LSB = 22, DIM0_MSB = 28.
  - FSM state encoding.
- Sub-module: the output stage is the existing axi_frs forward register slice, instantiated with DW = IRW*IN.
- Address/counter logic and the FSM stay in this module.

Test Plan:
- Basic run: base = 0x010, num = 2, out_ready = 1, RAM word at address a = a.
  - Two instructions out.
  - First = {0x012, 0x011, 0x010}, second = {0x015, 0x014, 0x013}.
  - Reads at 0x010..0x015 only.
  - done one cycle after the 2nd handshake; busy low afterwards.
- Zero length: num = 0 -> no ram_ren, no out_valid; done pulses within 2 cycles of start.
- Backpressure: num = 4, out_ready held 0 for 20 cycles, then 1.
  - out_inst stable while stalled.
  - At most one instruction buffered plus one in the slice; no reads beyond address base+5 during the stall.
  - All 4 instructions then delivered in order.
  - With the PERF macro defined, perf_stall_cnt = 20.
- Address wrap: base = 0x3FE, num = 2 -> read addresses 0x3FE, 0x3FF, 0x000, 0x001, 0x002, 0x003.
- Mid-run reset and ignored start: start with num = 3, assert rst_n low after the first handshake.
  - All outputs return to reset values; no done pulse.
  - New start with num = 1 completes normally.
  - A start pulse issued while busy is ignored (instruction count unchanged).
